trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap sequencer between the writeback/commit stage and the machine-mode CSR file.
- Arbitrates synchronous exceptions, mret, and pending interrupts (external/software/timer) at the commit boundary.
- Drains outstanding memory traffic, then issues single-cycle enter/leave pulses to the CSR file.
- Flushes the pipeline and redirects fetch to mtvec (direct or vectored) or mepc.

Parameters:
- VECTORED_EN, 1, honour mtvec[1:0]==1 vectored mode for interrupts; 0 = always direct.
- DRAIN_TIMEOUT, 255, maximum cycles spent in DRAIN before drain_err pulses; width = $clog2(DRAIN_TIMEOUT+1).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- commit_valid  in  1  instruction at commit this cycle
- commit_pc  in  64  its pc
- commit_exc  in  1  instruction raised a synchronous exception
- commit_code  in  63  exception cause
- commit_tval  in  64  exception value
- commit_mret  in  1  instruction is mret
- mem_busy  in  1  data-bus transaction outstanding
- csr_mstatus_mie  in  1  global interrupt enable from CSR file
- csr_mie  in  64  mie register
- csr_mip  in  64  mip register
- csr_mtvec  in  64  trap vector
- csr_mepc  in  64  return pc
- commit_squash  out  1  suppress architectural effects of current commit (regfile, CSR write)
- commit_stall  out  1  hold commit stage
- flush  out  1  kill all younger pipeline stages
- enter  out  1  one-cycle CSR trap-entry pulse
- leave  out  1  one-cycle CSR trap-return pulse
- trap_pc  out  64  mepc value for CSR file
- trap_interrupt  out  1  mcause[63]
- trap_code  out  63  mcause[62:0]
- trap_value  out  64  mtval value
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  64  new fetch pc
- drain_err  out  1  one-cycle pulse on drain timeout

Behaviour:
- Reset: clk, synchronous, active-high reset. FSM = IDLE; all outputs 0; latched trap fields 0; timeout counter 0.
- Reset mid-sequence: reset aborts any state immediately; no enter/leave is issued after reset.
- Interrupt selection (IDLE only): pend = csr_mip & csr_mie & {64{csr_mstatus_mie}}.
  - Priority: bit 11 (code 11) > bit 3 (code 3) > bit 7 (code 7).
  - Interrupts are sampled only when commit_valid=1.
- IDLE, commit_valid with pend!=0 (interrupt wins over commit_exc or commit_mret on the same instruction):
  - squash that instruction; latch pc=commit_pc, interrupt=1, code=selected, value=0.
  - Same cycle: commit_squash=1, flush=1. Go to DRAIN.
- IDLE, commit_valid & commit_exc, no pending interrupt:
  - latch pc=commit_pc, interrupt=0, code=commit_code, value=commit_tval.
  - commit_squash=1, flush=1. Go to DRAIN.
- IDLE, commit_valid & commit_mret, no exc/interrupt:
  - instruction commits normally; flush=1. Go to DRAIN with ret flag set.
- DRAIN:
  - flush=1 and commit_stall=1 every cycle.
  - Wait until mem_busy=0, then go to ENTER (or LEAVE if ret flag set).
  - Counter increments each DRAIN cycle. On reaching DRAIN_TIMEOUT: pulse drain_err once and proceed as if mem_busy=0.
- ENTER: enter=1 for exactly 1 cycle; trap_* hold latched values; flush=1, commit_stall=1. Go to REDIR.
- LEAVE: leave=1 for exactly 1 cycle; flush=1, commit_stall=1. Go to REDIR.
- REDIR: redirect_valid=1 for 1 cycle; flush=1, commit_stall=1. Go to IDLE.
  - Trap return: redirect_pc = csr_mepc.
  - Trap entry: base = {csr_mtvec[63:2],2'b00}.
    - If VECTORED_EN && csr_mtvec[1:0]==1 && interrupt: redirect_pc = base + (code<<2), truncated to 64 bits.
    - Otherwise redirect_pc = base.
- Latency: trigger at cycle T with mem_busy=0 -> DRAIN at T+1, enter/leave at T+2, redirect_valid at T+3, IDLE at T+4.
- trap_* outputs are driven only while enter=1, and are 0 otherwise.
- New commits and interrupts are ignored outside IDLE. The pipeline is stalled then, so commit_valid there is a protocol error; the bench asserts it never occurs.
- Back-to-back: a trap can trigger in the first IDLE cycle after REDIR.

Decomposition:
- Add to csr_pkg:
  - trap_state_t enum: IDLE, DRAIN, ENTER, LEAVE, REDIR.
  - trap_latch_t struct: pc, interrupt, code, value, ret.
  - INTERRUPT_* codes, already defined there.
- Sub-module irq_prio: combinational priority encoder, pend -> {any, code}.

Test Plan:
- commit_valid, commit_exc=1, code=2, pc=0x8000_0010, tval=0xDEAD, mem_busy=0, mtvec=0x8000_0100:
  - enter at T+2 with trap_pc=0x8000_0010, code=2, value=0xDEAD, interrupt=0.
  - redirect_pc=0x8000_0100 at T+3; commit_squash at T.
- mstatus_mie=1, mie=mip=0x888, commit at pc 0x8000_0020, mtvec=0x8000_0101:
  - code=11, interrupt=1.
  - redirect_pc=0x8000_012C.
- mie=0x80, mip=0x80, mstatus_mie=0 for 10 commits, then 1:
  - no trap for the first 10 commits.
  - trap code=7 on the first commit after the enable.
- commit_mret, mem_busy high 5 cycles, mepc=0x8000_0444:
  - leave fires exactly 1 cycle after mem_busy falls.
  - redirect_pc=0x8000_0444; no commit_squash.
- mem_busy stuck at 1 with DRAIN_TIMEOUT=255:
  - drain_err after 255 DRAIN cycles, followed by enter.
  - Separately, reset asserted in ENTER -> all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: interrupt cause codes and trap sequencer types.
package csr_pkg;

  localparam logic [62:0] INTERRUPT_MSI = 63'd3;
  localparam logic [62:0] INTERRUPT_MTI = 63'd7;
  localparam logic [62:0] INTERRUPT_MEI = 63'd11;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    ENTER,
    LEAVE,
    REDIR
  } trap_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic        interrupt;
    logic [62:0] code;
    logic [63:0] value;
    logic        ret;
  } trap_latch_t;

  // Vectored mode only applies to interrupts; the offset wraps within 64 bits.
  function automatic logic [63:0] trap_target(input logic [63:0] mtvec,
                                              input logic        interrupt,
                                              input logic [62:0] code,
                                              input logic        vectored_en);
    logic [63:0] base;
    base = {mtvec[63:2], 2'b00};
    if (vectored_en && (mtvec[1:0] == 2'b01) && interrupt)
      return base + {code[61:0], 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Fixed-priority encoder for machine interrupts: external > software > timer.
module irq_prio
  import csr_pkg::*;
(
  input  logic [63:0] pend,
  output logic        any,
  output logic [62:0] code
);

  // Only the three standard machine-level causes participate.
  logic unused_pend;
  assign unused_pend = ^{pend[63:12], pend[10:8], pend[6:4], pend[2:0]};

  always_comb begin
    any  = 1'b1;
    code = INTERRUPT_MEI;
    if (pend[11]) begin
      code = INTERRUPT_MEI;
    end else if (pend[3]) begin
      code = INTERRUPT_MSI;
    end else if (pend[7]) begin
      code = INTERRUPT_MTI;
    end else begin
      any  = 1'b0;
      code = '0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: picks exception/mret/interrupt at commit, drains memory traffic,
// pulses the CSR file, then redirects fetch.
module trap_ctrl
  import csr_pkg::*;
#(
  parameter bit VECTORED_EN   = 1'b1,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        commit_exc,
  input  logic [62:0] commit_code,
  input  logic [63:0] commit_tval,
  input  logic        commit_mret,
  input  logic        mem_busy,
  input  logic        csr_mstatus_mie,
  input  logic [63:0] csr_mie,
  input  logic [63:0] csr_mip,
  input  logic [63:0] csr_mtvec,
  input  logic [63:0] csr_mepc,
  output logic        commit_squash,
  output logic        commit_stall,
  output logic        flush,
  output logic        enter,
  output logic        leave,
  output logic [63:0] trap_pc,
  output logic        trap_interrupt,
  output logic [62:0] trap_code,
  output logic [63:0] trap_value,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        drain_err
);

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  trap_state_t state, state_next;
  trap_latch_t latched, latch_next;
  logic        latch_load;
  logic [CW-1:0] drain_cnt;

  logic [63:0] pend;
  logic        irq_any;
  logic [62:0] irq_code;

  assign pend = csr_mip & csr_mie & {64{csr_mstatus_mie}};

  irq_prio u_irq_prio (
    .pend (pend),
    .any  (irq_any),
    .code (irq_code)
  );

  // drain_cnt counts completed DRAIN cycles and clears whenever we leave DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      latched   <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_next;
      if (latch_load)
        latched <= latch_next;
      drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
    end
  end

  always_comb begin
    state_next     = state;
    latch_next     = latched;
    latch_load     = 1'b0;
    commit_squash  = 1'b0;
    commit_stall   = 1'b0;
    flush          = 1'b0;
    enter          = 1'b0;
    leave          = 1'b0;
    trap_pc        = '0;
    trap_interrupt = 1'b0;
    trap_code      = '0;
    trap_value     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    drain_err      = 1'b0;

    unique case (state)
      IDLE: begin
        // Reset is gated here so the same-cycle squash/flush stay low while held in reset.
        if (commit_valid && !reset) begin
          if (irq_any) begin
            latch_next.pc        = commit_pc;
            latch_next.interrupt = 1'b1;
            latch_next.code      = irq_code;
            latch_next.value     = '0;
            latch_next.ret       = 1'b0;
            latch_load           = 1'b1;
            commit_squash        = 1'b1;
            flush                = 1'b1;
            state_next           = DRAIN;
          end else if (commit_exc) begin
            latch_next.pc        = commit_pc;
            latch_next.interrupt = 1'b0;
            latch_next.code      = commit_code;
            latch_next.value     = commit_tval;
            latch_next.ret       = 1'b0;
            latch_load           = 1'b1;
            commit_squash        = 1'b1;
            flush                = 1'b1;
            state_next           = DRAIN;
          end else if (commit_mret) begin
            latch_next.pc        = commit_pc;
            latch_next.interrupt = 1'b0;
            latch_next.code      = '0;
            latch_next.value     = '0;
            latch_next.ret       = 1'b1;
            latch_load           = 1'b1;
            flush                = 1'b1;
            state_next           = DRAIN;
          end
        end
      end

      DRAIN: begin
        flush        = 1'b1;
        commit_stall = 1'b1;
        if (!mem_busy) begin
          state_next = latched.ret ? LEAVE : ENTER;
        end else if (drain_cnt == CNT_LAST) begin
          drain_err  = 1'b1;
          state_next = latched.ret ? LEAVE : ENTER;
        end
      end

      ENTER: begin
        enter          = 1'b1;
        flush          = 1'b1;
        commit_stall   = 1'b1;
        trap_pc        = latched.pc;
        trap_interrupt = latched.interrupt;
        trap_code      = latched.code;
        trap_value     = latched.value;
        state_next     = REDIR;
      end

      LEAVE: begin
        leave        = 1'b1;
        flush        = 1'b1;
        commit_stall = 1'b1;
        state_next   = REDIR;
      end

      REDIR: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        commit_stall   = 1'b1;
        redirect_pc    = latched.ret ? csr_mepc
                       : trap_target(csr_mtvec, latched.interrupt, latched.code, VECTORED_EN);
        state_next     = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: the driver predicts each trap from a behavioural model
// and queues it; a negedge monitor checks the CSR pulses and redirect against the queue.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        commit_exc;
  logic [62:0] commit_code;
  logic [63:0] commit_tval;
  logic        commit_mret;
  logic        mem_busy;
  logic        csr_mstatus_mie;
  logic [63:0] csr_mie;
  logic [63:0] csr_mip;
  logic [63:0] csr_mtvec;
  logic [63:0] csr_mepc;
  logic        commit_squash;
  logic        commit_stall;
  logic        flush;
  logic        enter;
  logic        leave;
  logic [63:0] trap_pc;
  logic        trap_interrupt;
  logic [62:0] trap_code;
  logic [63:0] trap_value;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        drain_err;

  trap_ctrl #(.VECTORED_EN(1'b1), .DRAIN_TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_exc(commit_exc),
    .commit_code(commit_code), .commit_tval(commit_tval), .commit_mret(commit_mret),
    .mem_busy(mem_busy), .csr_mstatus_mie(csr_mstatus_mie), .csr_mie(csr_mie),
    .csr_mip(csr_mip), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .commit_squash(commit_squash), .commit_stall(commit_stall), .flush(flush),
    .enter(enter), .leave(leave), .trap_pc(trap_pc), .trap_interrupt(trap_interrupt),
    .trap_code(trap_code), .trap_value(trap_value), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .drain_err(drain_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_ret;
    logic [63:0] pc;
    bit          intr;
    logic [62:0] code;
    logic [63:0] value;
    logic [63:0] rpc;
    int          trig_cyc;
    int          enter_cyc;
    bit          err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: which event a commit raises, straight from the priority rules.
  function automatic void model(input logic mie_g, input logic [63:0] mie, input logic [63:0] mip,
                                input logic exc, input logic mret,
                                output int kind, output logic [62:0] code);
    logic [63:0] p;
    p = mie_g ? (mip & mie) : 64'd0;
    kind = 0;
    code = '0;
    if (p[11])      begin kind = 1; code = 63'd11; end
    else if (p[3])  begin kind = 1; code = 63'd3;  end
    else if (p[7])  begin kind = 1; code = 63'd7;  end
    else if (exc)   kind = 2;
    else if (mret)  kind = 3;
  endfunction

  function automatic logic [63:0] model_target(input logic [63:0] mtvec, input bit intr,
                                               input logic [62:0] code);
    logic [63:0] base;
    base = mtvec - (mtvec % 64'd4);
    if (intr && (mtvec % 64'd4) == 64'd1)
      return base + 64'(code) * 64'd4;
    return base;
  endfunction

  // Monitor: every cycle inside a trap window is checked against the queued expectation.
  always @(negedge clk) begin
    if (commit_valid && commit_stall)
      check_output("protocol_commit_while_stalled", 64'(commit_stall), 64'd0);
    if (!reset) begin
      if (q.size() == 0) begin
        check_output("idle_quiet", 64'({enter, leave, redirect_valid, drain_err, commit_stall}), 64'd0);
      end else if (cyc > q[0].trig_cyc) begin
        mon_e = q[0];
        check_output("flush_stall", 64'({flush, commit_stall}), 64'd3);
        check_output("squash_window", 64'(commit_squash), 64'd0);
        check_output("enter", 64'(enter), 64'(!mon_e.is_ret && cyc == mon_e.enter_cyc));
        check_output("leave", 64'(leave), 64'(mon_e.is_ret && cyc == mon_e.enter_cyc));
        check_output("drain_err", 64'(drain_err), 64'(mon_e.err && cyc == mon_e.enter_cyc - 1));
        check_output("redirect_valid", 64'(redirect_valid), 64'(cyc == mon_e.enter_cyc + 1));
        if (enter) begin
          check_output("trap_pc", trap_pc, mon_e.pc);
          check_output("trap_interrupt", 64'(trap_interrupt), 64'(mon_e.intr));
          check_output("trap_code", 64'(trap_code), 64'(mon_e.code));
          check_output("trap_value", trap_value, mon_e.value);
        end else begin
          check_output("trap_fields_zero",
                       64'((|trap_pc) | (|trap_value) | (|trap_code) | trap_interrupt), 64'd0);
        end
        if (cyc == mon_e.enter_cyc + 1) begin
          check_output("redirect_pc", redirect_pc, mon_e.rpc);
          void'(q.pop_front());
        end
      end
    end
  end

  // Presents one commit at the current cycle (called at posedge+1) and returns at
  // posedge+1 of the first IDLE cycle after any resulting trap sequence.
  task automatic apply_stimulus(input logic [63:0] pc, input logic exc, input logic [62:0] code,
                                input logic [63:0] tval, input logic mret, input int b,
                                input logic mie_g, input logic [63:0] mie, input logic [63:0] mip,
                                input logic [63:0] mtvec, input logic [63:0] mepc);
    int kind;
    int t;
    int d;
    int budget;
    logic [62:0] icode;
    exp_t e;
    model(mie_g, mie, mip, exc, mret, kind, icode);
    commit_valid    = 1'b1;
    commit_pc       = pc;
    commit_exc      = exc;
    commit_code     = code;
    commit_tval     = tval;
    commit_mret     = mret;
    csr_mstatus_mie = mie_g;
    csr_mie         = mie;
    csr_mip         = mip;
    csr_mtvec       = mtvec;
    csr_mepc        = mepc;
    mem_busy        = (b > 0);
    t = cyc;
    @(negedge clk);
    check_output("commit_squash", 64'(commit_squash), 64'(kind == 1 || kind == 2));
    check_output("flush_at_commit", 64'(flush), 64'(kind != 0));
    if (kind != 0) begin
      e.is_ret   = (kind == 3);
      e.pc       = pc;
      e.intr     = (kind == 1);
      e.code     = (kind == 1) ? icode : code;
      e.value    = (kind == 2) ? tval : 64'd0;
      e.rpc      = (kind == 3) ? mepc : model_target(mtvec, kind == 1, e.code);
      e.trig_cyc = t;
      d = (b < 1) ? 1 : b;
      e.err = (d > 255);
      if (d > 255) d = 255;
      e.enter_cyc = t + 1 + d;
      q.push_back(e);
    end
    step();
    commit_valid = 1'b0;
    commit_exc   = 1'b0;
    commit_mret  = 1'b0;
    mem_busy     = ((cyc - t) < b);
    if (kind != 0) begin
      budget = 0;
      while (q.size() != 0 && budget < 600) begin
        step();
        mem_busy = ((cyc - t) < b);
        budget++;
      end
      if (q.size() != 0) begin
        check_output("redirect_timeout", 64'(q.size()), 64'd0);
        q.delete();
      end
    end
  endtask

  function automatic logic [63:0] rand_irq();
    logic [63:0] v;
    v = '0;
    v[3]  = 1'($urandom_range(0, 1));
    v[7]  = 1'($urandom_range(0, 1));
    v[11] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic reset_in_enter();
    exp_t e;
    int t;
    commit_valid = 1'b1;
    commit_pc    = 64'h8000_0300;
    commit_exc   = 1'b1;
    commit_code  = 63'd5;
    commit_tval  = 64'h1234;
    commit_mret  = 1'b0;
    csr_mstatus_mie = 1'b0;
    mem_busy     = 1'b0;
    t = cyc;
    e.is_ret = 1'b0; e.pc = 64'h8000_0300; e.intr = 1'b0; e.code = 63'd5;
    e.value = 64'h1234; e.rpc = '0; e.trig_cyc = t; e.enter_cyc = t + 2; e.err = 1'b0;
    q.push_back(e);
    step();
    commit_valid = 1'b0;
    commit_exc   = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check_output("enter_before_reset", 64'(enter), 64'd1);
    step();
    q.delete();
    @(negedge clk);
    check_output("reset_outputs_zero",
                 64'(|{commit_squash, commit_stall, flush, enter, leave, trap_pc, trap_interrupt,
                       trap_code, trap_value, redirect_valid, redirect_pc, drain_err}), 64'd0);
    step();
    reset = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] r64;
    logic [63:0] r64b;
    reset = 1'b1;
    commit_valid = 1'b0; commit_pc = '0; commit_exc = 1'b0; commit_code = '0;
    commit_tval = '0; commit_mret = 1'b0; mem_busy = 1'b0; csr_mstatus_mie = 1'b0;
    csr_mie = '0; csr_mip = '0; csr_mtvec = '0; csr_mepc = '0;
    repeat (3) step();
    @(negedge clk);
    check_output("reset_state",
                 64'(|{commit_squash, commit_stall, flush, enter, leave, trap_pc, trap_interrupt,
                       trap_code, trap_value, redirect_valid, redirect_pc, drain_err}), 64'd0);
    step();
    reset = 1'b0;
    step();

    $display("[TB] synchronous exception");
    apply_stimulus(64'h8000_0010, 1'b1, 63'd2, 64'hDEAD, 1'b0, 0,
                   1'b0, 64'd0, 64'd0, 64'h8000_0100, 64'd0);

    $display("[TB] vectored external interrupt");
    apply_stimulus(64'h8000_0020, 1'b0, 63'd0, 64'd0, 1'b0, 0,
                   1'b1, 64'h888, 64'h888, 64'h8000_0101, 64'd0);

    $display("[TB] masked timer interrupt then enable");
    for (int i = 0; i < 10; i++)
      apply_stimulus(64'h8000_0100 + 64'(4 * i), 1'b0, 63'd0, 64'd0, 1'b0, 0,
                     1'b0, 64'h80, 64'h80, 64'h8000_0101, 64'd0);
    apply_stimulus(64'h8000_0200, 1'b0, 63'd0, 64'd0, 1'b0, 0,
                   1'b1, 64'h80, 64'h80, 64'h8000_0101, 64'd0);

    $display("[TB] mret with busy memory");
    apply_stimulus(64'h8000_0400, 1'b0, 63'd0, 64'd0, 1'b1, 5,
                   1'b0, 64'd0, 64'd0, 64'h8000_0100, 64'h8000_0444);

    $display("[TB] drain timeout");
    apply_stimulus(64'h8000_0500, 1'b1, 63'd13, 64'h77, 1'b0, 300,
                   1'b0, 64'd0, 64'd0, 64'h8000_0100, 64'd0);
    mem_busy = 1'b0;

    $display("[TB] reset during ENTER");
    reset_in_enter();

    $display("[TB] randomized commits");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) step();
      r64  = {$urandom(), $urandom()};
      r64b = {$urandom(), $urandom()};
      apply_stimulus({r64[63:2], 2'b00},
                     1'($urandom_range(0, 9) < 3),
                     r64b[62:0],
                     {$urandom(), $urandom()},
                     1'($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 6)),
                     1'($urandom_range(0, 1)),
                     rand_irq(), rand_irq(),
                     {r64b[63:2], 2'($urandom_range(0, 3))},
                     {$urandom(), $urandom()});
    end

    mem_busy = 1'b0;
    repeat (5) step();
    check_output("queue_empty_at_end", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
